// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx -- UART transmitter
//
// Sends one byte per frame on tx: a start bit (0), eight data bits LSB
// first, an optional even-parity bit, then pSTOP_BITS stop bits (1). The line
// idles high. Bytes come in over a valid/ready handshake. tx_data is sampled
// only in the accept cycle, so the source may change it freely afterwards.
//
// Every bit lasts exactly BIT_CYCLES = pSYS_CLK_FREQ / pBAUD_RATE sys_clk
// cycles (integer-truncated, no fractional-rate compensation). This matches
// the receiver on the same link, so both ends agree on bit timing.
//
// Optional feature:
//   UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the 8 data
//                      bits) is inserted between the data and stop bits.
//                      When undefined, no parity state or logic exists.
//
// Parameters:
//   pBAUD_RATE     line bit rate, bits/s
//   pSYS_CLK_FREQ  sys_clk frequency, Hz
//   pSTOP_BITS     stop bits per frame (1 or 2)
//
// Ports:
//   sys_clk   in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   tx_valid  in   byte available on tx_data
//   tx_data   in   byte to send, sampled on accept
//   tx_ready  out  idle, a byte can be accepted this cycle
//   tx        out  serial line, registered, idles high
//   tx_busy   out  frame in progress (~tx_ready)
//   tx_done   out  one-cycle pulse during the last cycle of the final stop bit
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int pBAUD_RATE    = 9600,
    parameter int pSYS_CLK_FREQ = 100000000,
    parameter int pSTOP_BITS    = 1
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BIT_CYCLES = pSYS_CLK_FREQ / pBAUD_RATE;
    // A one-cycle bit would give a zero-width counter, so keep at least 1 bit.
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [2:0]       DATA_LAST = 3'd7;
    localparam logic [2:0]       STOP_LAST = 3'(pSTOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;     // cycle within the current bit
    logic [2:0]       bit_q, bit_d;       // data bit index, reused as stop bit index
    logic [7:0]       shift_q, shift_d;   // shift_q[0] is the bit on the line
    logic             tx_q, tx_d;
    logic             done;
    logic             bit_end;

`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BAUD_LAST);

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default value first. A path
    // that leaves one unassigned would make synthesis infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (tx_valid) begin
                    state_d = S_START;
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end

            S_START: begin
                baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
                if (bit_end) begin
                    // The shift register already holds bit 0 in position 0,
                    // so entering DATA needs no shift.
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end

            S_DATA: begin
                baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
`endif

            S_STOP: begin
                baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        // This is the last cycle of the frame. The following
                        // cycle is an idle-high cycle in which tx_ready is set.
                        done    = 1'b1;
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // The line level is computed from the *next* state and registered. The
    // pin then changes on the same edge as the state, and no input has a
    // combinational path to tx.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples its input before any register updates, so the order of
    // the statements has no effect on the result.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx       = tx_q;
    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx_done  = done;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx -- testbench for uart_tx
//
// Three instances:
//   u_dut  fast config (16 cycles/bit), 1 stop bit; scoreboard + line monitor
//   u_dut2 fast config, 2 stop bits; stop-length and latency checks
//   u_def  default parameters; start-bit length (10416 cycles)
// Outputs are sampled on the falling edge of sys_clk. Inputs are driven on
// the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int BC = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB1    = 1 + 8 + PB + 1;
    localparam int FRAME1 = NB1 * BC;
    localparam int FRAME2 = (1 + 8 + PB + 2) * BC;
    localparam int DEF_BC = 10416;

    typedef struct {
        logic [7:0] data;
        logic       par;   // hand-computed even parity of data
    } exp_t;

    logic       sys_clk;
    logic       rst;
    logic       rst_def;

    logic       tx_valid, tx_ready, tx, tx_busy, tx_done;
    logic [7:0] tx_data;
    logic       tx_valid2, tx_ready2, tx2, tx_busy2, tx_done2;
    logic [7:0] tx_data2;
    logic       valid_d, ready_d, tx_def, busy_d, done_d;
    logic [7:0] data_d;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    uart_tx #(.pBAUD_RATE(100000), .pSYS_CLK_FREQ(1600000), .pSTOP_BITS(1)) u_dut (
        .sys_clk(sys_clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx #(.pBAUD_RATE(100000), .pSYS_CLK_FREQ(1600000), .pSTOP_BITS(2)) u_dut2 (
        .sys_clk(sys_clk), .rst(rst), .tx_valid(tx_valid2), .tx_data(tx_data2),
        .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    uart_tx u_def (
        .sys_clk(sys_clk), .rst(rst_def), .tx_valid(valid_d), .tx_data(data_d),
        .tx_ready(ready_d), .tx(tx_def), .tx_busy(busy_d), .tx_done(done_d)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: decodes frames on u_dut's line and compares them with the scoreboard
    // ------------------------------------------------------------------
    bit          mon_active = 0;
    int          mon_cyc;
    int          frames_seen = 0;
    exp_t        cur;
    logic [15:0] samp;
    logic        line_prev;
    bit          unstable;
    bit          early_done;
    int          bi;
    int          off;

    always @(negedge sys_clk) begin
        if (!rst) begin
            if (tx_done) check("done_in_reset", tx_done, 0);
            mon_active = 0;
        end else if (!mon_active) begin
            if (tx_done) check("stray_done", tx_done, 0);
            if (tx === 1'b0) begin
                mon_active = 1;
                mon_cyc    = 0;
                unstable   = 0;
                early_done = 0;
                samp       = '0;
                if (sb_q.size() == 0) begin
                    check("unexpected_frame", sb_q.size(), 1);
                    cur = '{8'h00, 1'b0};
                end else begin
                    cur = sb_q.pop_front();
                end
            end
        end

        if (rst && mon_active) begin
            bi  = mon_cyc / BC;
            off = mon_cyc % BC;
            if (off == BC / 2) samp[bi] = tx;
            if (off != 0 && tx !== line_prev) unstable = 1;
            line_prev = tx;
            if (mon_cyc == FRAME1 - 1) begin
                check("start_bit", samp[0], 0);
                check("data_byte", samp[8:1], cur.data);
`ifdef UART_TX_PARITY_EN
                check("parity_bit", samp[9], cur.par);
`endif
                check("stop_bit", samp[NB1-1], 1);
                check("bit_stable", unstable, 0);
                check("done_at_end", tx_done, 1);
                check("done_early", early_done, 0);
                mon_active = 0;
                frames_seen++;
            end else begin
                if (tx_done) early_done = 1;
                mon_cyc++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Raises valid, waits for ready, records the expected frame, lets the
    // accept edge pass and returns on the first falling edge of the frame.
    task automatic send(input logic [7:0] d, input logic p);
        int n;
        @(negedge sys_clk);
        tx_valid = 1'b1;
        tx_data  = d;
        n = 0;
        while (!tx_ready && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        if (!tx_ready) check("ready_timeout", tx_ready, 1);
        sb_q.push_back('{d, p});
        @(posedge sys_clk);
        @(negedge sys_clk);
        tx_valid = 1'b0;
    endtask

    // Counts falling edges from the current one until tx_done is seen.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!tx_done && cyc < 1000) begin
            @(negedge sys_clk);
            cyc++;
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int cyc;
        int hi;

        rst = 1'b0; rst_def = 1'b0;
        tx_valid = 1'b0;  tx_data = 8'h00;
        tx_valid2 = 1'b0; tx_data2 = 8'h00;
        valid_d = 1'b0;   data_d = 8'h00;

        #23;
        check("rst_tx", tx, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_tx2", tx2, 1);
        @(negedge sys_clk);
        #2 rst = 1'b1; rst_def = 1'b1;

        fork
            // Default parameters: start bit lasts 10416 cycles, then bit0 of 0x01.
            begin
                int lo;
                @(negedge sys_clk);
                valid_d = 1'b1;
                data_d  = 8'h01;
                check("def_ready", ready_d, 1);
                @(posedge sys_clk);
                @(negedge sys_clk);
                valid_d = 1'b0;
                lo = 0;
                while (tx_def == 1'b0 && lo < DEF_BC + 100) begin
                    lo++;
                    @(negedge sys_clk);
                end
                check("def_start_len", lo, DEF_BC);
                check("def_bit0", tx_def, 1);
                #2 rst_def = 1'b0;
                #1 check("def_abort_ready", ready_d, 1);
            end

            begin
                // 0x59: line 0,1,0,0,1,1,0,1,0,1; tx_done 160 cycles after accept.
                send(8'h59, 1'b0);
                wait_done(cyc);
                check("lat_59", cyc, FRAME1 - 1);
                @(negedge sys_clk);
                check("ready_after_59", tx_ready, 1);

                // Back-to-back 0xA5 then 0x3C with tx_valid held high.
                @(negedge sys_clk);
                tx_valid = 1'b1;
                tx_data  = 8'hA5;
                check("b2b_ready_first", tx_ready, 1);
                sb_q.push_back('{8'hA5, 1'b0});
                @(posedge sys_clk);
                @(negedge sys_clk);
                tx_data = 8'h3C;
                sb_q.push_back('{8'h3C, 1'b0});
                wait_done(cyc);
                check("lat_a5", cyc, FRAME1 - 1);
                @(negedge sys_clk);
                check("gap_ready", tx_ready, 1);
                check("gap_line", tx, 1);
                @(negedge sys_clk);
                check("b2b_ready_low", tx_ready, 0);
                check("b2b_start", tx, 0);
                tx_valid = 1'b0;
                wait_done(cyc);
                check("lat_3c", cyc, FRAME1 - 1);

                // Busy drop: 0xFF offered during the data phase of 0x00.
                send(8'h00, 1'b0);
                repeat (40) @(negedge sys_clk);
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
                repeat (40) @(negedge sys_clk);
                tx_valid = 1'b0;
                wait_done(cyc);
                check("lat_00", cyc, FRAME1 - 1 - 80);
                repeat (30) @(negedge sys_clk);
                check("busy_no_extra", sb_q.size(), 0);
                check("busy_idle_line", tx, 1);

                // Reset during data bit 3 of 0x81.
                send(8'h81, 1'b0);
                repeat (70) @(negedge sys_clk);
                #2 rst = 1'b0;
                #1;
                check("mid_rst_tx", tx, 1);
                check("mid_rst_ready", tx_ready, 1);
                check("mid_rst_busy", tx_busy, 0);
                check("mid_rst_done", tx_done, 0);
                @(negedge sys_clk);
                #2 rst = 1'b1;
                send(8'h81, 1'b0);
                wait_done(cyc);
                check("lat_81", cyc, FRAME1 - 1);

                // Odd-weight byte: parity bit 1 when parity is enabled.
                send(8'h58, 1'b1);
                wait_done(cyc);
                check("lat_58", cyc, FRAME1 - 1);

                // Two stop bits on u_dut2, byte 0x00.
                @(negedge sys_clk);
                tx_valid2 = 1'b1;
                tx_data2  = 8'h00;
                check("s2_ready", tx_ready2, 1);
                @(posedge sys_clk);
                @(negedge sys_clk);
                tx_valid2 = 1'b0;
                cyc = 0;
                hi  = 0;
                while (!tx_done2 && cyc < 500) begin
                    if (tx2) hi++;
                    @(negedge sys_clk);
                    cyc++;
                end
                if (tx2) hi++;
                check("s2_latency", cyc, FRAME2 - 1);
                check("s2_stop_len", hi, 2 * BC);
                @(negedge sys_clk);
                check("s2_ready_after", tx_ready2, 1);
            end
        join

        repeat (5) @(negedge sys_clk);
        check("frames_seen", frames_seen, 6);
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
